tristate_bus_ctrl: RTL and testbench

Sequencer directly upstream of the tristate buffer stage on the shared 4-bit bus. Accepts single-beat read/write requests over a valid/ready handshake. Drives the buffer's data input and enable with a fixed drive window followed by a turnaround gap. For reads, it releases the bus, samples the resolved bus value after a programmable delay, and returns it as a one-cycle response.

---
 rtl/tristate_pkg.sv | 13 +
 rtl/tristate_bus_ctrl_phase_counter.sv | 18 +
 rtl/tristate_bus_ctrl.sv | 102 ++++++++++
 tb/tb_tristate_bus_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tristate_pkg.sv
// tristate_pkg: shared types and defaults for the tristate bus sequencer
package tristate_pkg;
  localparam int BUS_WIDTH      = 4;
  localparam int HOLD_DEF       = 2;
  localparam int TURN_DEF       = 1;
  localparam int SAMPLE_DLY_DEF = 1;
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN, S_SAMPLE} state_t;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/tristate_bus_ctrl_phase_counter.sv
// phase_counter: loadable saturating down-counter with zero flag
// ports: clk, reset (async high), load/load_val (load takes priority), zero (count is 0)
module phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - W'(1));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/tristate_bus_ctrl.sv
// tristate_bus_ctrl: sequences single-beat reads/writes onto a shared tristate bus
// ports: req_valid/req_ready/req_write/req_data request handshake; d_out/en drive the
// tristate buffer; bus_in is the resolved bus; rsp_valid/rsp_data return read data; busy
module tristate_bus_ctrl
  import tristate_pkg::*;
#(
  parameter int WIDTH      = BUS_WIDTH,
  parameter int HOLD       = HOLD_DEF,
  parameter int TURN       = TURN_DEF,
  parameter int SAMPLE_DLY = SAMPLE_DLY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] d_out,
  output logic             en,
  input  logic [WIDTH-1:0] bus_in,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);
  localparam int CW = $clog2(max3(HOLD, TURN, SAMPLE_DLY) + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN > 0 ? TURN - 1 : 0);
  localparam logic [CW-1:0] SMP_LD  = CW'(SAMPLE_DLY - 1);

  if (HOLD < 1 || SAMPLE_DLY < 1 || TURN < 0) begin : g_bad_params
    $error("tristate_bus_ctrl: illegal HOLD/TURN/SAMPLE_DLY");
  end

  state_t           state_q, state_d;
  logic             en_q, en_d, rsp_valid_q, rsp_valid_d, cnt_ld, cnt_zero;
  logic [WIDTH-1:0] d_out_q, d_out_d, rsp_data_q, rsp_data_d;
  logic [CW-1:0]    cnt_val;

  phase_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_ld),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    d_out_d     = d_out_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    cnt_ld      = 1'b0;
    cnt_val     = '0;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        cnt_ld  = 1'b1;
        cnt_val = req_write ? HOLD_LD : SMP_LD;
        state_d = req_write ? S_DRIVE : S_SAMPLE;
        en_d    = req_write;
        d_out_d = req_write ? req_data : '0;
      end
      S_DRIVE: if (cnt_zero) begin
        cnt_ld  = 1'b1;
        cnt_val = TURN_LD;
        state_d = (TURN > 0) ? S_TURN : S_IDLE;
        en_d    = 1'b0;
        d_out_d = '0;
      end
      S_TURN: state_d = cnt_zero ? S_IDLE : S_TURN;
      S_SAMPLE: if (cnt_zero) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus_in;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      d_out_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      d_out_q     <= d_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end

  // reset is folded in so no request is offered while the block is held in reset
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign busy      = state_q != S_IDLE;
  assign en        = en_q;
  assign d_out     = d_out_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// tb_tristate_bus_ctrl: directed bench with read-response scoreboard for two parameterisations
module tb_tristate_bus_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid_a = 1'b0, req_valid_b = 1'b0, req_write = 1'b0;
  logic [3:0] req_data = 4'h0, bus_in = 4'h0;
  logic req_ready_a, en_a, rsp_valid_a, busy_a;
  logic req_ready_b, en_b, rsp_valid_b, busy_b;
  logic [3:0] d_out_a, rsp_data_a, d_out_b, rsp_data_b;
  int checks = 0, errors = 0, cyc = 0, en_hi_a = 0;
  logic [3:0] qa[$], qb[$];
  logic [3:0] ea, eb;
  logic oka, okb;

  always #5 clk = ~clk;

  tristate_bus_ctrl dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_data(req_data), .d_out(d_out_a), .en(en_a),
    .bus_in(bus_in), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a)
  );

  tristate_bus_ctrl #(.HOLD(3), .TURN(0), .SAMPLE_DLY(2)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_data(req_data), .d_out(d_out_b), .en(en_b),
    .bus_in(bus_in), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b)
  );

  always @(negedge clk) begin
    if (en_a) en_hi_a++;
    if (rsp_valid_a) begin
      checks++;
      oka = qa.size() != 0;
      ea  = oka ? qa.pop_front() : 4'hx;
      assert (oka && rsp_data_a === ea) else begin
        errors++;
        $error("FAIL rsp_a observed %0h expected %0h (queued=%0d)", rsp_data_a, ea, oka);
      end
    end
    if (rsp_valid_b) begin
      checks++;
      okb = qb.size() != 0;
      eb  = okb ? qb.pop_front() : 4'hx;
      assert (okb && rsp_data_b === eb) else begin
        errors++;
        $error("FAIL rsp_b observed %0h expected %0h (queued=%0d)", rsp_data_b, eb, okb);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // holds the request valid until accepted; returns the accept cycle, read data is pushed at drive time
  task automatic send(input bit b, input logic w, input logic [3:0] d, output int acc);
    logic r;
    acc = -1;
    req_write = w;
    req_data  = d;
    if (!w) begin
      if (b) qb.push_back(bus_in);
      else qa.push_back(bus_in);
    end
    if (b) req_valid_b = 1'b1;
    else req_valid_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r = b ? req_ready_b : req_ready_a;
      tick();
      if (r) begin
        acc = cyc;
        break;
      end
    end
    chk("accept", acc >= 0, 1);
  endtask

  initial begin
    int k, k1, k2, k3, base;
    logic r, seen;
    req_valid_a = 1'b1;
    req_valid_b = 1'b1;
    req_write   = 1'b1;
    req_data    = 4'h7;
    repeat (2) tick();
    chk("rst_en", en_a, 0);
    chk("rst_dout", d_out_a, 0);
    chk("rst_rsp", rsp_valid_a, 0);
    chk("rst_ready", req_ready_a, 0);
    chk("rst_rdata", rsp_data_a, 0);
    chk("rst_busy", busy_a, 0);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    #2 reset = 1'b0;
    #1 chk("ready_after_rst", req_ready_a, 1);

    send(0, 1'b1, 4'hA, k);
    req_valid_a = 1'b0;
    chk("w_en1", en_a, 1);
    chk("w_d1", d_out_a, 4'hA);
    chk("w_rdy1", req_ready_a, 0);
    tick();
    chk("w_en2", en_a, 1);
    chk("w_d2", d_out_a, 4'hA);
    tick();
    chk("w_en_turn", en_a, 0);
    chk("w_d_turn", d_out_a, 0);
    chk("w_busy_turn", busy_a, 1);
    chk("w_rdy_turn", req_ready_a, 0);
    tick();
    chk("w_ready", req_ready_a, 1);
    chk("w_idle", busy_a, 0);

    bus_in = 4'h5;
    send(0, 1'b0, 4'h0, k);
    req_valid_a = 1'b0;
    chk("r_en", en_a, 0);
    chk("r_rsp0", rsp_valid_a, 0);
    chk("r_busy", busy_a, 1);
    tick();
    chk("r_rsp1", rsp_valid_a, 1);
    chk("r_data", rsp_data_a, 4'h5);
    chk("r_ready", req_ready_a, 1);
    chk("r_en1", en_a, 0);
    bus_in = 4'h9;
    tick();
    chk("r_rsp2", rsp_valid_a, 0);
    chk("r_hold", rsp_data_a, 4'h5);

    bus_in = 4'h6;
    base = en_hi_a;
    send(0, 1'b1, 4'h3, k1);
    send(0, 1'b1, 4'hC, k2);
    send(0, 1'b0, 4'h0, k3);
    req_valid_a = 1'b0;
    repeat (3) tick();
    chk("b2b_ww_spacing", k2 - k1, 4);
    chk("b2b_wr_spacing", k3 - k2, 4);
    chk("b2b_en_cycles", en_hi_a - base, 4);

    send(0, 1'b1, 4'hF, k);
    req_valid_a = 1'b0;
    chk("rd_en1", en_a, 1);
    #3 reset = 1'b1;
    #1 chk("rd_en_async", en_a, 0);
    chk("rd_d_async", d_out_a, 0);
    #3 reset = 1'b0;
    tick();

    bus_in      = 4'h3;
    req_write   = 1'b0;
    req_valid_a = 1'b1;
    r = req_ready_a;
    tick();
    req_valid_a = 1'b0;
    chk("ms_accept", r, 1);
    chk("ms_busy", busy_a, 1);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | rsp_valid_a;
    end
    chk("ms_no_rsp", seen, 0);

    send(1, 1'b1, 4'h9, k);
    req_valid_b = 1'b0;
    chk("b_en1", en_b, 1);
    chk("b_d1", d_out_b, 4'h9);
    tick();
    chk("b_en2", en_b, 1);
    tick();
    chk("b_en3", en_b, 1);
    tick();
    chk("b_en4", en_b, 0);
    chk("b_d4", d_out_b, 0);
    chk("b_ready4", req_ready_b, 1);

    bus_in = 4'hB;
    send(1, 1'b1, 4'h2, k1);
    send(1, 1'b0, 4'h0, k2);
    req_valid_b = 1'b0;
    chk("b_wr_spacing", k2 - k1, 4);
    chk("b_rsp0", rsp_valid_b, 0);
    tick();
    chk("b_rsp1", rsp_valid_b, 0);
    tick();
    chk("b_rsp2", rsp_valid_b, 1);
    chk("b_rdata", rsp_data_b, 4'hB);
    tick();
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
